// File: rtl/tetris_key_cmd.sv
// Turns held PS/2 key state into one-at-a-time Tetris commands with DAS auto-repeat.
// The key inputs are asynchronous to clk, so they are synchronised and only acted on once stable.
module tetris_key_cmd #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DAS_DELAY = 170,
  parameter int unsigned DAS_RATE  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_on,
  input  logic [7:0] key1_code,
  input  logic       key2_on,
  input  logic [7:0] key2_code,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready
);

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_DOWN   = 3'd3;
  localparam logic [2:0] CMD_ROTATE = 3'd4;
  localparam logic [2:0] CMD_DROP   = 3'd5;

  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DELAY_LAST = 8'(DAS_DELAY - 1);
  localparam logic [7:0]  RATE_LAST  = 8'(DAS_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT,
    HOLD_NOREP
  } move_state_e;

  logic [17:0] s1_q, s2_q;
  logic [2:0]  d1_d, d1_q, d1_prev_q;
  logic        d2_d, d2_q, d2_prev_q;
  logic        rot_state_d, rot_state_q;
  move_state_e state_d, state_q;
  logic [2:0]  held_d, held_q;
  logic [15:0] presc_d, presc_q;
  logic [7:0]  tick_cnt_d, tick_cnt_q;
  logic        move_pend_d, move_pend_q;
  logic [2:0]  move_code_d, move_code_q;
  logic        rot_pend_d, rot_pend_q;
  logic        cmd_valid_d, cmd_valid_q;
  logic [2:0]  cmd_d, cmd_q;

  logic       stable1, stable2, tick, load_ok;
  logic       move_evt, rot_evt, move_take, rot_take;
  logic [2:0] move_evt_code;

  assign stable1   = (d1_q == d1_prev_q);
  assign stable2   = (d2_q == d2_prev_q);
  assign tick      = (presc_q == TICK_LAST);
  assign load_ok   = !cmd_valid_q || cmd_ready;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

  always_comb begin
    d1_d = CMD_NONE;
    if (s2_q[17]) begin
      case (s2_q[16:9])
        8'h6B:   d1_d = CMD_LEFT;
        8'h74:   d1_d = CMD_RIGHT;
        8'h72:   d1_d = CMD_DOWN;
        8'h75:   d1_d = CMD_DROP;
        default: d1_d = CMD_NONE;
      endcase
    end
    d2_d = s2_q[8] && (s2_q[7:0] == 8'h12);
  end

  // A stable release or a stable new code overrides whatever repeat the counters would produce.
  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    presc_d       = presc_q;
    tick_cnt_d    = tick_cnt_q;
    move_evt      = 1'b0;
    move_evt_code = held_q;

    if (state_q == HOLD_DELAY || state_q == HOLD_REPEAT) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (tick) tick_cnt_d = tick_cnt_q + 8'd1;
    end

    case (state_q)
      HOLD_DELAY: begin
        if (tick && tick_cnt_q == DELAY_LAST) begin
          move_evt   = 1'b1;
          state_d    = HOLD_REPEAT;
          presc_d    = 16'd0;
          tick_cnt_d = 8'd0;
        end
      end
      HOLD_REPEAT: begin
        if (tick && tick_cnt_q == RATE_LAST) begin
          move_evt   = 1'b1;
          presc_d    = 16'd0;
          tick_cnt_d = 8'd0;
        end
      end
      default: ;
    endcase

    if (stable1) begin
      if (d1_q == CMD_NONE) begin
        state_d    = IDLE;
        move_evt   = 1'b0;
        presc_d    = 16'd0;
        tick_cnt_d = 8'd0;
      end else if (state_q == IDLE || d1_q != held_q) begin
        move_evt      = 1'b1;
        move_evt_code = d1_q;
        held_d        = d1_q;
        state_d       = (d1_q == CMD_DROP) ? HOLD_NOREP : HOLD_DELAY;
        presc_d       = 16'd0;
        tick_cnt_d    = 8'd0;
      end
    end
  end

  always_comb begin
    rot_state_d = rot_state_q;
    rot_evt     = 1'b0;
    if (stable2) begin
      rot_state_d = d2_q;
      rot_evt     = d2_q && !rot_state_q;
    end
  end

  // Rotate wins the output slot; a flag set in the same cycle it is loaded stays set.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    rot_take    = 1'b0;
    move_take   = 1'b0;
    if (load_ok) begin
      if (rot_pend_q) begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_ROTATE;
        rot_take    = 1'b1;
      end else if (move_pend_q) begin
        cmd_valid_d = 1'b1;
        cmd_d       = move_code_q;
        move_take   = 1'b1;
      end else begin
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_NONE;
      end
    end
    rot_pend_d  = (rot_pend_q && !rot_take) || rot_evt;
    move_pend_d = (move_pend_q && !move_take) || move_evt;
    move_code_d = move_evt ? move_evt_code : move_code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      d1_q        <= CMD_NONE;
      d1_prev_q   <= CMD_NONE;
      d2_q        <= 1'b0;
      d2_prev_q   <= 1'b0;
      rot_state_q <= 1'b0;
      state_q     <= IDLE;
      held_q      <= CMD_NONE;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      move_pend_q <= 1'b0;
      move_code_q <= CMD_NONE;
      rot_pend_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      s1_q        <= {key1_on, key1_code, key2_on, key2_code};
      s2_q        <= s1_q;
      d1_q        <= d1_d;
      d1_prev_q   <= d1_q;
      d2_q        <= d2_d;
      d2_prev_q   <= d2_q;
      rot_state_q <= rot_state_d;
      state_q     <= state_d;
      held_q      <= held_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      move_pend_q <= move_pend_d;
      move_code_q <= move_code_d;
      rot_pend_q  <= rot_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

endmodule

// File: tb/tb_tetris_key_cmd.sv
// Self-checking bench for tetris_key_cmd: accepted commands are logged with their cycle
// and compared against expectations built from press/release times and DAS arithmetic.
module tb_tetris_key_cmd;

  localparam int TD = 4;
  localparam int DD = 3;
  localparam int DR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key1_on = 1'b0;
  logic [7:0] key1_code = 8'hF0;
  logic       key2_on = 1'b0;
  logic [7:0] key2_code = 8'hF0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rec_cyc[$], rec_cmd[$], exp_cyc[$], exp_cmd[$];

  tetris_key_cmd #(.TICK_DIV(TD), .DAS_DELAY(DD), .DAS_RATE(DR)) dut (
    .clk(clk), .rst(rst),
    .key1_on(key1_on), .key1_code(key1_code),
    .key2_on(key2_on), .key2_code(key2_code),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshake that will complete at the coming rising edge.
  always begin
    @(negedge clk);
    #3;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      rec_cyc.push_back(cyc);
      rec_cmd.push_back(int'(cmd));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rec_cyc.delete(); rec_cmd.delete(); exp_cyc.delete(); exp_cmd.delete();
  endtask

  function automatic int key1_cmd(input logic on, input logic [7:0] code);
    if (!on) return 0;
    case (code)
      8'h6B:   return 1;
      8'h74:   return 2;
      8'h72:   return 3;
      8'h75:   return 5;
      default: return 0;
    endcase
  endfunction

  // A press driven after edge k is seen 6 edges later; repeats follow at DAS offsets
  // for as long as the offset is below the hold length.
  function automatic void add_hold(input int k, input int h, input int c);
    int off;
    if (c == 0 || h < 2) return;
    off = 0;
    while (off < h) begin
      exp_cyc.push_back(k + 6 + off);
      exp_cmd.push_back(c);
      if (c == 5) break;
      off = (off == 0) ? DD * TD : off + DR * TD;
    end
  endfunction

  task automatic hold_key1(input logic on, input logic [7:0] code, input int h);
    int k;
    k = cyc;
    key1_on = on; key1_code = code;
    step(h);
    key1_on = 1'b0; key1_code = 8'hF0;
    add_hold(k, h, key1_cmd(on, code));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, expected 0", cmd_valid); end
    checks++;
    if (cmd !== 3'd0) begin failures++; $display("[TB] FAIL reset_cmd: got %0d, expected 0", cmd); end
    rst = 1'b0;
    clear_logs();
    step(12);
    checks++;
    if (rec_cyc.size() !== 0) begin failures++; $display("[TB] FAIL reset_idle: got %0d commands, expected 0", rec_cyc.size()); end
  endtask

  task automatic test_hold_repeat();
    clear_logs();
    hold_key1(1'b1, 8'h6B, 30);
    step(12);
    checks++;
    if (rec_cyc.size() !== exp_cyc.size()) begin failures++; $display("[TB] FAIL repeat_count: got %0d, expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL repeat_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_random_holds();
    logic [7:0] codes[3] = '{8'h6B, 8'h74, 8'h72};
    logic [7:0] code;
    int kind;
    clear_logs();
    repeat (8) begin
      kind = $urandom_range(0, 4);
      if (kind <= 2) begin
        hold_key1(1'b1, codes[kind], $urandom_range(1, 45));
      end else if (kind == 3) begin
        code = 8'($urandom_range(0, 255));
        while (key1_cmd(1'b1, code) != 0) code = 8'($urandom_range(0, 255));
        hold_key1(1'b1, code, $urandom_range(2, 30));
      end else begin
        hold_key1(1'b0, 8'h6B, $urandom_range(2, 30));
      end
      step(10);
    end
    checks++;
    if (rec_cyc.size() !== exp_cyc.size()) begin failures++; $display("[TB] FAIL random_count: got %0d, expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL random_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_drop();
    clear_logs();
    hold_key1(1'b1, 8'h75, 200);
    step(10);
    checks++;
    if (rec_cyc.size() !== 1) begin failures++; $display("[TB] FAIL drop_count: got %0d, expected 1", rec_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL drop_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_rotate_backpressure();
    int bad;
    clear_logs();
    cmd_ready = 1'b0;
    key2_on = 1'b1; key2_code = 8'h12;
    step(3);
    key2_on = 1'b0; key2_code = 8'hF0;
    step(2);
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rot_latency: valid=%b one cycle early, expected 0", cmd_valid); end
    step(1);
    bad = 0;
    repeat (50) begin
      if (cmd_valid !== 1'b1 || cmd !== 3'd4) bad++;
      step(1);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL rot_hold: %0d cycles not valid cmd=4, expected 0", bad); end
    cmd_ready = 1'b1;
    step(1);
    checks++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin failures++; $display("[TB] FAIL rot_after_accept: got valid=%b cmd=%0d, expected 0/0", cmd_valid, cmd); end
    step(5);
    checks++;
    if (rec_cyc.size() !== 1) begin failures++; $display("[TB] FAIL rot_accept_count: got %0d, expected 1", rec_cyc.size()); end
    else begin
      checks++;
      if (rec_cmd[0] !== 4) begin failures++; $display("[TB] FAIL rot_accept_cmd: got %0d, expected 4", rec_cmd[0]); end
    end
  endtask

  task automatic test_simultaneous();
    int k;
    clear_logs();
    k = cyc;
    key1_on = 1'b1; key1_code = 8'h74;
    key2_on = 1'b1; key2_code = 8'h12;
    step(6);
    key1_on = 1'b0; key1_code = 8'hF0;
    key2_on = 1'b0; key2_code = 8'hF0;
    step(10);
    exp_cyc.push_back(k + 6); exp_cmd.push_back(4);
    exp_cyc.push_back(k + 7); exp_cmd.push_back(2);
    checks++;
    if (rec_cyc.size() !== exp_cyc.size()) begin failures++; $display("[TB] FAIL simul_count: got %0d, expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL simul_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_skew();
    int k, h1;
    clear_logs();
    h1 = $urandom_range(4, 10);
    k = cyc;
    key1_on = 1'b1; key1_code = 8'h6B;
    step(h1);
    key1_code = 8'h7B;
    step(1);
    key1_code = 8'h74;
    step(6);
    key1_on = 1'b0; key1_code = 8'hF0;
    step(12);
    exp_cyc.push_back(k + 6);      exp_cmd.push_back(1);
    exp_cyc.push_back(k + h1 + 7); exp_cmd.push_back(2);
    checks++;
    if (rec_cyc.size() !== exp_cyc.size()) begin failures++; $display("[TB] FAIL skew_count: got %0d, expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL skew_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int k, k2;
    clear_logs();
    k = cyc;
    key1_on = 1'b1; key1_code = 8'h74;
    step(22);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin failures++; $display("[TB] FAIL midreset_out: got valid=%b cmd=%0d, expected 0/0", cmd_valid, cmd); end
    k2 = cyc;
    step(30);
    key1_on = 1'b0; key1_code = 8'hF0;
    step(12);
    exp_cyc.push_back(k + 6);  exp_cmd.push_back(2);
    exp_cyc.push_back(k + 18); exp_cmd.push_back(2);
    add_hold(k2, 30, 2);
    checks++;
    if (rec_cyc.size() !== exp_cyc.size()) begin failures++; $display("[TB] FAIL midreset_count: got %0d, expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < rec_cyc.size() && i < exp_cyc.size(); i++) begin
      checks++;
      if (rec_cyc[i] !== exp_cyc[i] || rec_cmd[i] !== exp_cmd[i]) begin
        failures++;
        $display("[TB] FAIL midreset_cmd[%0d]: got cmd=%0d @%0d, expected cmd=%0d @%0d", i, rec_cmd[i], rec_cyc[i], exp_cmd[i], exp_cyc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_random_holds();
    test_drop();
    test_rotate_backpressure();
    test_simultaneous();
    test_skew();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
